// File: rtl/vga_timing.sv
// vga_timing: free-running VGA pixel/line counters with registered sync and blank flags.
// Flags are computed from the next-count values so counts and flags describe the same pixel.
module vga_timing #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FRONT  = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BACK   = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FRONT  = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BACK   = 29
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic        frame_start
);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

   // run is low straight out of reset so the first edge lands on pixel (0,0)
   logic        run;
   logic [10:0] h_nxt, v_nxt;
   logic        h_wrap;

   always_comb begin
      h_wrap = hcount_out == H_LAST;
      h_nxt  = (!run || h_wrap) ? 11'd0 : hcount_out + 11'd1;
      v_nxt  = !run ? 11'd0 : !h_wrap ? vcount_out : (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run         <= 1'b0;
         hcount_out  <= '0;
         vcount_out  <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         run         <= 1'b1;
         hcount_out  <= h_nxt;
         vcount_out  <= v_nxt;
         hsync_out   <= h_nxt >= HS_BEG && h_nxt < HS_END;
         vsync_out   <= v_nxt >= VS_BEG && v_nxt < VS_END;
         hblnk_out   <= h_nxt >= H_ACT;
         vblnk_out   <= v_nxt >= V_ACT;
         frame_start <= h_nxt == 11'd0 && v_nxt == 11'd0;
      end
   end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing; a full-size instance covers line timing,
// a shrunken instance covers frame wrap, vsync/vblnk and frame_start period.
module tb_vga_timing;
   localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4, SVA = 6, SVF = 1, SVS = 2, SVB = 3;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;

   logic        clk, rst;
   logic [10:0] b_h, b_v, s_h, s_v;
   logic        b_hs, b_vs, b_hb, b_vb, b_fs, s_hs, s_vs, s_hb, s_vb, s_fs;

   vga_timing u_big (
      .clk(clk), .rst(rst), .hcount_out(b_h), .vcount_out(b_v), .hsync_out(b_hs),
      .vsync_out(b_vs), .hblnk_out(b_hb), .vblnk_out(b_vb), .frame_start(b_fs));

   vga_timing #(.H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)) u_small (
      .clk(clk), .rst(rst), .hcount_out(s_h), .vcount_out(s_v), .hsync_out(s_hs),
      .vsync_out(s_vs), .hblnk_out(s_hb), .vblnk_out(s_vb), .frame_start(s_fs));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [26:0] q_big[$], q_small[$];
   int bh = 0, bv = 0, br = 0, sh = 0, sv = 0, sr = 0;
   int cyc_no = 0, hs_run = 0, last_fs = -1, vs_run = 0;

   function automatic logic [26:0] expv(int ha, int hf, int hs, int va, int vf, int vs, int h, int v, int r);
      if (r == 0) return '0;
      return {11'(h), 11'(v), h >= ha + hf && h < ha + hf + hs, v >= va + vf && v < va + vf + vs,
              h >= ha, v >= va, h == 0 && v == 0};
   endfunction

   task automatic adv(input int ht, input int vt, inout int h, inout int v, inout int r);
      if (!rst) begin
         h = 0; v = 0; r = 0;
      end else if (r == 0) begin
         h = 0; v = 0; r = 1;
      end else if (h == ht - 1) begin
         h = 0;
         v = (v == vt - 1) ? 0 : v + 1;
      end else h = h + 1;
   endtask

   task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs h=%0d v=%0d hs/vs/hb/vb/fs=%b exp h=%0d v=%0d hs/vs/hb/vb/fs=%b",
                tag, obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
      end
   endtask

   task automatic cnt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         adv(1344, 806, bh, bv, br);
         adv(SHT, SVT, sh, sv, sr);
         q_big.push_back(expv(1024, 24, 136, 768, 3, 6, bh, bv, br));
         q_small.push_back(expv(SHA, SHF, SHS, SVA, SVF, SVS, sh, sv, sr));
         @(posedge clk);
         #1;
         cyc_no++;
         chk("big", {b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_fs}, q_big.pop_front());
         chk("small", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs}, q_small.pop_front());
         if (b_h == 0 && hs_run > 0) begin
            cnt("hsync_width", hs_run, 136);
            hs_run = 0;
         end
         if (b_hs) hs_run++;
         if (s_fs) begin
            if (last_fs >= 0) begin
               cnt("frame_period", cyc_no - last_fs, SHT * SVT);
               cnt("vsync_width", vs_run, SVS * SHT);
            end
            last_fs = cyc_no;
            vs_run = 0;
         end
         if (s_vs) vs_run++;
      end
   endtask

   initial begin
      rst = 1'b1;
      #1 rst = 1'b0;
      cyc(5);
      rst = 1'b1;
      cyc(2 * 1344 + 501);
      cnt("mid_h", int'(b_h), 500);
      #2 rst = 1'b0;
      #1;
      chk("async_big", {b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_fs}, '0);
      chk("async_small", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs}, '0);
      hs_run = 0;
      last_fs = -1;
      vs_run = 0;
      cyc(3);
      #3 rst = 1'b1;
      cyc(1344 + 1100);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Parameters
REQ-001 H_ACTIVE, 1024, visible pixels per line.
REQ-002 H_FRONT, 24, horizontal front porch, in pixels.
REQ-003 H_SYNC, 136, hsync pulse width, in pixels.
REQ-004 H_BACK, 160, horizontal back porch; H_TOTAL = sum of the four H terms = 1344.
REQ-005 V_ACTIVE, 768, visible lines per frame.
REQ-006 V_FRONT, 3, vertical front porch, in lines.
REQ-007 V_SYNC, 6, vsync pulse width, in lines.
REQ-008 V_BACK, 29, vertical back porch; V_TOTAL = sum of the four V terms = 806.

Interface
REQ-009 clk  input  1  pixel clock, 65 MHz; the only clock in the block.
REQ-010 rst  input  1  reset; asynchronous assert, active-low.
REQ-011 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-012 vcount_out  output  11  current line, 0..V_TOTAL-1.
REQ-013 hsync_out  output  1  high during the horizontal sync pulse.
REQ-014 vsync_out  output  1  high during the vertical sync pulse.
REQ-015 hblnk_out  output  1  high outside the horizontal active region.
REQ-016 vblnk_out  output  1  high outside the vertical active region.
REQ-017 frame_start  output  1  one-cycle pulse on pixel (0,0).

Function
REQ-018 All outputs SHALL be driven directly from flip-flops; no combinational path from any input to any output.
REQ-019 All outputs SHALL describe the same pixel (hcount_out, vcount_out) in the same cycle, with zero skew between counts and flags. Flags are therefore registered from the next-count values.
REQ-020 hcount SHALL increment by 1 every clk cycle.
REQ-021 hcount wrap: at H_TOTAL-1 = 1343, hcount SHALL return to 0 on the next cycle.
REQ-022 vcount SHALL increment only in the cycle where hcount wraps.
REQ-023 vcount wrap: at V_TOTAL-1 = 805, when hcount also wraps, vcount SHALL return to 0.
REQ-024 hblnk_out SHALL be 1 exactly when hcount >= H_ACTIVE, i.e. 1024..1343.
REQ-025 hsync_out SHALL be 1 exactly for hcount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [1048, 1183].
REQ-026 vblnk_out SHALL be 1 exactly when vcount >= V_ACTIVE, i.e. 768..805, for every hcount of those lines.
REQ-027 vsync_out SHALL be 1 exactly for vcount in [771, 776], for every hcount of those lines.
REQ-028 frame_start SHALL be 1 only in the cycle where hcount_out = 0 and vcount_out = 0.
REQ-029 Frame period SHALL be H_TOTAL*V_TOTAL = 1,083,264 cycles; hsync and hblnk period SHALL be 1344 cycles.
REQ-030 Counter arithmetic SHALL be 11-bit unsigned. Widths SHALL cover H_TOTAL-1 and V_TOTAL-1 with no overflow for any parameter set below 2048.
REQ-031 Sync polarity at the block boundary SHALL be active-high. Any inversion the monitor requires is done downstream of this block.

Reset
REQ-032 While rst = 0, all outputs SHALL be 0 asynchronously: hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, frame_start.
REQ-033 The first clk edge after rst deasserts SHALL present pixel (0,0) with frame_start = 1, then counting proceeds per REQ-020.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately. The restart SHALL follow REQ-033, with no partial-line or partial-frame carry-over.

Verification
REQ-035 Reset release: hold rst = 0 for 5 cycles, then release -> all outputs 0 during reset; first edge after release gives (0,0) with frame_start = 1; the next cycle gives hcount = 1 with frame_start = 0.
REQ-036 Line boundaries: run one line -> hblnk rises at hcount = 1024; hsync is high on 1048..1183 (136 cycles); hcount 1343 is followed by 0; vcount increments by 1 on that wrap.
REQ-037 Frame boundaries: run one full frame -> vblnk is high on lines 768..805; vsync is high on lines 771..776 (6*1344 = 8064 cycles); after (1343, 805) the next pixel is (0,0) with frame_start = 1; frame_start recurs every 1,083,264 cycles.
REQ-038 Asynchronous reset mid-frame: assert rst between clock edges at (500, 400) -> outputs go to 0 without waiting for clk; after release the sequence restarts at (0,0).
REQ-039 Checker invariants over 2 frames: hblnk = (hcount >= 1024); vblnk = (vcount >= 768); hcount never exceeds 1343; vcount never exceeds 805; frame_start appears only at (0,0).
